// File: rtl/expansion_port_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : expansion_port_bridge
//  Purpose  : Converts asynchronous C64 expansion-port IO1/IO2 accesses into
//             single-clock read/write strobes for the register block, and
//             drives the block's registered read data back onto the bus.
//  Revision : 1.0 - initial release
// ============================================================================
module expansion_port_bridge #(
   parameter int WRITE_DELAY = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       phi2,
   input  logic       io_n,
   input  logic       rw,
   input  logic [7:0] bus_a,
   input  logic [7:0] bus_d_in,
   output logic [7:0] bus_d_out,
   output logic       bus_d_oe,
   output logic [7:0] reg_a,
   output logic [7:0] reg_d_d,
   input  logic [7:0] reg_d_q,
   output logic       read_strobe,
   output logic       write_strobe,
   output logic       write_abort
);

   localparam logic [3:0] c_WR_CNT_INIT = 4'(WRITE_DELAY - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_STB  = 3'd1,
      S_RD_CAP  = 3'd2,
      S_RD_HOLD = 3'd3,
      S_WR_WAIT = 3'd4,
      S_WR_STB  = 3'd5,
      S_END     = 3'd6
   } state_t;

   logic       r_phi2_meta, r_phi2_sync;
   logic       r_io_n_meta, r_io_n_sync;
   logic       r_rw_meta,   r_rw_sync;
   logic [1:0] r_warm;
   logic       r_armed;
   state_t     r_state;
   logic [3:0] r_cnt;
   logic [7:0] r_bus_d_out, r_reg_a, r_reg_d_d;
   logic       r_bus_d_oe, r_read_strobe, r_write_strobe, r_write_abort;
   logic       w_start;

   // Two-flop synchronizers for the asynchronous bus control lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phi2_meta <= 1'b0;
         r_phi2_sync <= 1'b0;
         r_io_n_meta <= 1'b1;
         r_io_n_sync <= 1'b1;
         r_rw_meta   <= 1'b0;
         r_rw_sync   <= 1'b0;
      end else begin
         r_phi2_meta <= phi2;
         r_phi2_sync <= r_phi2_meta;
         r_io_n_meta <= io_n;
         r_io_n_sync <= r_io_n_meta;
         r_rw_meta   <= rw;
         r_rw_sync   <= r_rw_meta;
      end
   end

   // After reset, wait for the synchronizers to refill and for PHI2 to be
   // seen low, so a bus cycle already in progress at release is ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_warm  <= 2'b00;
         r_armed <= 1'b0;
      end else begin
         r_warm <= {r_warm[0], 1'b1};
         if (r_warm[1] && !r_phi2_sync)
            r_armed <= 1'b1;
      end
   end

   assign w_start = r_armed && r_phi2_sync && !r_io_n_sync;

   // Bus-cycle state machine with registered strobes and bus drive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= 4'd0;
         r_bus_d_out    <= 8'h00;
         r_bus_d_oe     <= 1'b0;
         r_reg_a        <= 8'h00;
         r_reg_d_d      <= 8'h00;
         r_read_strobe  <= 1'b0;
         r_write_strobe <= 1'b0;
         r_write_abort  <= 1'b0;
      end else begin
         r_read_strobe  <= 1'b0;
         r_write_strobe <= 1'b0;
         r_write_abort  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  if (r_rw_sync) begin
                     r_reg_a       <= bus_a;
                     r_read_strobe <= 1'b1;
                     r_state       <= S_RD_STB;
                  end else begin
                     r_cnt   <= c_WR_CNT_INIT;
                     r_state <= S_WR_WAIT;
                  end
               end
            end
            S_RD_STB: begin
               r_state <= S_RD_CAP;
            end
            S_RD_CAP: begin
               r_bus_d_out <= reg_d_q;
               r_bus_d_oe  <= 1'b1;
               r_state     <= S_RD_HOLD;
            end
            S_RD_HOLD: begin
               if (!r_phi2_sync) begin
                  r_bus_d_oe <= 1'b0;
                  r_state    <= S_IDLE;
               end else if (r_io_n_sync) begin
                  r_bus_d_oe <= 1'b0;
                  r_state    <= S_END;
               end
            end
            S_WR_WAIT: begin
               if (!r_phi2_sync || r_io_n_sync) begin
                  r_write_abort <= 1'b1;
                  r_state       <= r_phi2_sync ? S_END : S_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_reg_a        <= bus_a;
                  r_reg_d_d      <= bus_d_in;
                  r_write_strobe <= 1'b1;
                  r_state        <= S_WR_STB;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_WR_STB: begin
               r_state <= S_END;
            end
            S_END: begin
               // One strobe per PHI2-high phase: hold until PHI2 drops
               if (!r_phi2_sync)
                  r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus_d_out    = r_bus_d_out;
   assign bus_d_oe     = r_bus_d_oe;
   assign reg_a        = r_reg_a;
   assign reg_d_d      = r_reg_d_d;
   assign read_strobe  = r_read_strobe;
   assign write_strobe = r_write_strobe;
   assign write_abort  = r_write_abort;

endmodule
`default_nettype wire

// File: tb/tb_expansion_port_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_expansion_port_bridge
//  Purpose  : Scoreboard bench for expansion_port_bridge with a simple
//             registered register-block model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_expansion_port_bridge;

   localparam int WD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       phi2 = 1'b0;
   logic       io_n = 1'b1;
   logic       rw = 1'b1;
   logic [7:0] bus_a = 8'h00;
   logic [7:0] bus_d_in = 8'h00;
   logic [7:0] reg_d_q = 8'h00;
   logic [7:0] bus_d_out, reg_a, reg_d_d;
   logic       bus_d_oe, read_strobe, write_strobe, write_abort;

   expansion_port_bridge #(.WRITE_DELAY(WD)) dut (
      .clk          (clk),
      .rst          (rst),
      .phi2         (phi2),
      .io_n         (io_n),
      .rw           (rw),
      .bus_a        (bus_a),
      .bus_d_in     (bus_d_in),
      .bus_d_out    (bus_d_out),
      .bus_d_oe     (bus_d_oe),
      .reg_a        (reg_a),
      .reg_d_d      (reg_d_d),
      .reg_d_q      (reg_d_q),
      .read_strobe  (read_strobe),
      .write_strobe (write_strobe),
      .write_abort  (write_abort)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-block model: registered read data, unaffected by bridge reset
   logic [7:0] mem [256];
   bit loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= (i == 0) ? 8'h42 : 8'h00;
         loaded <= 1'b1;
      end else begin
         if (write_strobe) mem[reg_a] <= reg_d_d;
         if (read_strobe)  reg_d_q <= mem[reg_a];
      end
   end

   // kind: 0 read strobe, 1 write strobe, 2 write abort, 3 oe rise, 4 oe fall
   typedef struct {
      int         kind;
      logic [7:0] a;
      logic [7:0] d;
      int         when;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } snap_t;

   exp_t  sbq[$];
   snap_t dq[$];
   int    n_cmp = 0;
   int    n_err = 0;
   bit    done = 1'b0;

   task automatic push(input int k, input logic [7:0] a, input logic [7:0] d, input int w);
      exp_t e;
      e.kind = k; e.a = a; e.d = d; e.when = w;
      sbq.push_back(e);
   endtask

   task automatic snap(input string n, input logic [31:0] act, input logic [31:0] exp);
      snap_t s;
      s.name = n; s.act = act; s.exp = exp;
      dq.push_back(s);
   endtask

   task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
      end
   endtask

   task automatic ev(input int k, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      n_cmp++;
      if (sbq.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: kind %0d a=0x%0h d=0x%0h at cycle %0d, nothing expected", k, a, d, cyc);
      end else begin
         e = sbq.pop_front();
         if (e.kind != k || e.a !== a || e.d !== d || e.when != cyc) begin
            n_err++;
            $display("FAIL event: got kind %0d a=0x%0h d=0x%0h cycle %0d, expected kind %0d a=0x%0h d=0x%0h cycle %0d",
                     k, a, d, cyc, e.kind, e.a, e.d, e.when);
         end
      end
   endtask

   // Monitor: sample away from the active edge, pop and compare
   initial begin
      logic prev_oe;
      prev_oe = 1'b0;
      forever begin
         @(negedge clk);
         while (dq.size() > 0) begin
            snap_t s;
            s = dq.pop_front();
            cmp(s.name, s.act, s.exp);
         end
         if (read_strobe)            ev(0, reg_a, 8'h00);
         if (write_strobe)           ev(1, reg_a, reg_d_d);
         if (write_abort)            ev(2, 8'h00, 8'h00);
         if (bus_d_oe && !prev_oe)   ev(3, 8'h00, bus_d_out);
         if (!bus_d_oe && prev_oe)   ev(4, 8'h00, 8'h00);
         if (read_strobe && write_strobe) begin
            n_err++;
            $display("FAIL both_strobes: read_strobe=1 write_strobe=1 at cycle %0d, required not both", cyc);
         end
         prev_oe = bus_d_oe;
         if (done) begin
            cmp("pending_expected", sbq.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
         end
      end
   end

   // One PHI2 cycle with io_n low; expectations derived from the raw timing
   task automatic bus_cycle(input bit is_rd, input logic [7:0] a, input logic [7:0] d,
                            input int high, input bit exp_abort, input bit flip_rw,
                            input logic [7:0] rdata);
      int c;
      @(negedge clk);
      c = cyc;
      rw = is_rd; bus_a = a; bus_d_in = d; phi2 = 1'b1; io_n = 1'b0;
      if (exp_abort) begin
         push(2, 8'h00, 8'h00, c + high + 3);
      end else if (is_rd) begin
         push(0, a, 8'h00, c + 3);
         push(3, 8'h00, rdata, c + 5);
         push(4, 8'h00, 8'h00, c + high + 3);
      end else begin
         push(1, a, d, c + 3 + WD);
      end
      for (int i = 0; i < high; i++) begin
         @(negedge clk);
         if (flip_rw && i == high / 2) rw = ~rw;
      end
      phi2 = 1'b0; io_n = 1'b1; rw = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   // Stimulus
   initial begin
      int r;
      repeat (3) @(negedge clk);
      snap("rst_bus_d_out", bus_d_out, 0);
      snap("rst_bus_d_oe", bus_d_oe, 0);
      snap("rst_reg_a", reg_a, 0);
      snap("rst_reg_d_d", reg_d_d, 0);
      snap("rst_strobes", {read_strobe, write_strobe, write_abort}, 0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      snap("idle_outputs", {bus_d_oe, read_strobe, write_strobe, write_abort}, 0);

      bus_cycle(1'b1, 8'h00, 8'h00, 25, 1'b0, 1'b0, 8'h42);   // basic read
      bus_cycle(1'b0, 8'h02, 8'h5A, 25, 1'b0, 1'b0, 8'h00);   // write
      bus_cycle(1'b1, 8'h02, 8'h00, 25, 1'b0, 1'b0, 8'h5A);   // read back
      bus_cycle(1'b0, 8'h03, 8'h77, 3,  1'b1, 1'b0, 8'h00);   // aborted write
      bus_cycle(1'b1, 8'h03, 8'h00, 25, 1'b0, 1'b0, 8'h00);   // nothing written

      // Qualification: io_n without PHI2, PHI2 without io_n
      @(negedge clk);
      io_n = 1'b0;
      repeat (10) @(negedge clk);
      snap("qual_oe_a", bus_d_oe, 0);
      io_n = 1'b1; phi2 = 1'b1;
      repeat (10) @(negedge clk);
      snap("qual_oe_b", bus_d_oe, 0);
      phi2 = 1'b0;
      repeat (6) @(negedge clk);

      bus_cycle(1'b1, 8'h00, 8'h00, 200, 1'b0, 1'b1, 8'h42);  // long read, rw flips
      bus_cycle(1'b0, 8'h04, 8'h99, 200, 1'b0, 1'b1, 8'h00);  // long write, rw flips
      bus_cycle(1'b1, 8'h04, 8'h00, 25, 1'b0, 1'b0, 8'h99);

      // Reset while the read data is being driven
      @(negedge clk);
      r = cyc;
      rw = 1'b1; bus_a = 8'h00; phi2 = 1'b1; io_n = 1'b0;
      push(0, 8'h00, 8'h00, r + 3);
      push(3, 8'h00, 8'h42, r + 5);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2;
      push(4, 8'h00, 8'h00, cyc);
      rst = 1'b1;
      #1;
      snap("oe_async_reset", bus_d_oe, 0);
      snap("strobe_async_reset", {read_strobe, write_strobe}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      snap("no_strobe_after_reset", {bus_d_oe, read_strobe, write_strobe, write_abort}, 0);
      phi2 = 1'b0; io_n = 1'b1;
      repeat (6) @(negedge clk);
      bus_cycle(1'b1, 8'h02, 8'h00, 25, 1'b0, 1'b0, 8'h5A);   // normal again

      repeat (5) @(negedge clk);
      done = 1'b1;
   end

endmodule
`default_nettype wire
